// File: rtl/ripple_capture.sv
// Purpose : synchronise a 4-bit ripple counter, filter settling codes, extend to EXT_W bits.
// Latency : q_in change before edge 1 -> rd_valid/count at edge 2+STABLE_N.
// Backpr. : count held while rd_valid && !rd_ready; accepts arriving then are dropped and flag overrun.
//
// Optional feature macro: RIPPLE_CAPTURE_EXT_EN
//   defined     -> wrap-around tracker present, count[EXT_W-1:4] = upper
//   not defined -> tracker removed, count[EXT_W-1:4] = 0 (wrap_pulse still reported)
//
// Ports:
//   clk        capture clock, all state updates on rising edge
//   reset      synchronous, active-low reset
//   q_in       raw ripple counter outputs, asynchronous to clk
//   rd_valid   count holds an unconsumed accepted value
//   rd_ready   consumer takes count on an edge with rd_valid && rd_ready
//   count      {upper, nibble} of the last loaded value
//   wrap_pulse one-cycle pulse after the edge a wrap is accepted
//   overrun    sticky: a value was accepted while the output was full and not being read

module ripple_capture #(
    parameter int EXT_W    = 12,
    parameter int STABLE_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       q_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [EXT_W-1:0] count,
    output logic             wrap_pulse,
    output logic             overrun
);

    localparam int         UW       = EXT_W - 4;
    localparam logic [3:0] STAB_N   = 4'(STABLE_N);
    localparam logic [3:0] STAB_NM1 = 4'(STABLE_N - 1);

    // Elaboration-time parameter sanity.
    generate
        if (EXT_W < 5) begin : g_bad_ext_w
            $error("ripple_capture: EXT_W must be >= 5");
        end
        if (STABLE_N < 1 || STABLE_N > 15) begin : g_bad_stable_n
            $error("ripple_capture: STABLE_N must be in 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]       r_s1;
    logic [3:0]       r_s2;
    logic [3:0]       r_cand;
    logic [3:0]       r_stab;
    logic [3:0]       r_last;
    logic             r_rd_valid;
    logic [EXT_W-1:0] r_count;
    logic             r_wrap_pulse;
    logic             r_overrun;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             w_diff;
    logic             w_settle;
    logic [3:0]       w_new_val;
    logic             w_accept;
    logic             w_wrap;
    logic             w_load;
    logic             w_read;
    logic [UW-1:0]    w_upper_nxt;

    assign w_diff = (r_s2 != r_cand);

    // The value settles on the edge stab reaches STABLE_N. With STABLE_N=1
    // that is the very edge cand reloads, so the settled value is s2 itself
    // rather than the (stale) cand.
    assign w_settle  = (STABLE_N == 1) ? w_diff : (!w_diff && (r_stab == STAB_NM1));
    assign w_new_val = w_diff ? r_s2 : r_cand;

    // Only a value different from the last accepted one is an event; any
    // decrease (including a counter reset to 0) is treated as a wrap.
    assign w_accept = w_settle && (w_new_val != r_last);
    assign w_wrap   = w_accept && (w_new_val < r_last);

    assign w_read = r_rd_valid && rd_ready;
    assign w_load = w_accept && (!r_rd_valid || rd_ready);

`ifdef RIPPLE_CAPTURE_EXT_EN
    logic [UW-1:0] r_upper;

    // Upper count rolls over naturally at 2^(EXT_W-4).
    assign w_upper_nxt = r_upper + UW'(w_wrap);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upper <= '0;
        end else begin
            r_upper <= w_upper_nxt;
        end
    end
`else
    assign w_upper_nxt = '0;
`endif

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1 <= 4'd0;
            r_s2 <= 4'd0;
        end else begin
            r_s1 <= q_in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Stability filter and last-accepted tracker
    // ------------------------------------------------------------------
    // stab resets to STABLE_N so the all-zero reset state counts as already
    // settled: a zero input after reset generates no event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cand <= 4'd0;
            r_stab <= STAB_N;
            r_last <= 4'd0;
        end else begin
            if (w_diff) begin
                r_cand <= r_s2;
                r_stab <= 4'd1;
            end else if (r_stab < STAB_N) begin
                r_stab <= r_stab + 4'd1;
            end

            if (w_accept) begin
                r_last <= w_new_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_valid   <= 1'b0;
            r_count      <= '0;
            r_wrap_pulse <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap;

            if (w_load) begin
                // Simultaneous read and accept: new value replaces the
                // consumed one and rd_valid stays asserted.
                r_count    <= {w_upper_nxt, w_new_val};
                r_rd_valid <= 1'b1;
            end else if (w_accept) begin
                // Output full and not being drained: hold count, drop the
                // new value from the output path only.
                r_overrun <= 1'b1;
            end else if (w_read) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign rd_valid   = r_rd_valid;
    assign count      = r_count;
    assign wrap_pulse = r_wrap_pulse;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ripple_capture.sv
module tb_ripple_capture;

    localparam int EXT_W    = 12;
    localparam int STABLE_N = 2;

    logic             clk;
    logic             reset;
    logic [3:0]       q_in;
    logic             rd_valid;
    logic             rd_ready;
    logic [EXT_W-1:0] count;
    logic             wrap_pulse;
    logic             overrun;

    int n_vec;
    int n_err;

    ripple_capture #(
        .EXT_W    (EXT_W),
        .STABLE_N (STABLE_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .count      (count),
        .wrap_pulse (wrap_pulse),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply a new ripple value with rd_ready=1, wait for its accept and check
    // the loaded count and wrap pulse, then confirm the read drains it.
    task automatic step(input string tag, input logic [3:0] v,
                        input logic [31:0] exp_cnt, input logic exp_wrap);
        logic got;
        got  = 1'b0;
        q_in = v;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (rd_valid) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_cnt"},  32'(count), exp_cnt);
            chk({tag, "_wrap"}, 32'(wrap_pulse), 32'(exp_wrap));
            tick();
            chk({tag, "_drain"},   32'(rd_valid), 32'd0);
            chk({tag, "_wrapclr"}, 32'(wrap_pulse), 32'd0);
        end
        repeat (3) tick();
    endtask

    initial begin
        logic got;
        logic [31:0] e14, e15, e0, e1;

`ifdef RIPPLE_CAPTURE_EXT_EN
        e14 = 32'd14; e15 = 32'd15; e0 = 32'd16; e1 = 32'd17;
`else
        e14 = 32'd14; e15 = 32'd15; e0 = 32'd0;  e1 = 32'd1;
`endif

        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        q_in     = 4'd0;
        rd_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_vld",  32'(rd_valid),   32'd0);
        chk("rst_cnt",  32'(count),      32'd0);
        chk("rst_wrap", 32'(wrap_pulse), 32'd0);
        chk("rst_ovr",  32'(overrun),    32'd0);
        reset = 1'b1;

        // Idle at zero: nothing is ever accepted
        repeat (6) begin
            tick();
            chk("idle_vld", 32'(rd_valid), 32'd0);
        end
        chk("idle_cnt",  32'(count),      32'd0);
        chk("idle_wrap", 32'(wrap_pulse), 32'd0);

        // 0 -> 5 with consumer stalled: appears at edge 4, held until read
        rd_ready = 1'b0;
        q_in     = 4'd5;
        tick();
        tick();
        tick();
        chk("lat_e3_vld", 32'(rd_valid), 32'd0);
        tick();
        chk("lat_e4_vld", 32'(rd_valid), 32'd1);
        chk("lat_e4_cnt", 32'(count),    32'd5);
        repeat (3) tick();
        chk("hold_vld", 32'(rd_valid), 32'd1);
        chk("hold_cnt", 32'(count),    32'd5);
        rd_ready = 1'b1;
        tick();
        chk("read_vld", 32'(rd_valid), 32'd0);
        chk("read_cnt", 32'(count),    32'd5);

        // One-cycle glitch to 7 inside a stable 5
        q_in = 4'd7;
        tick();
        q_in = 4'd5;
        repeat (8) begin
            tick();
            chk("glitch_vld", 32'(rd_valid), 32'd0);
        end
        chk("glitch_cnt", 32'(count), 32'd5);

        // 14 -> 15 -> 0 -> 1: one wrap on the 0
        step("s14", 4'd14, e14, 1'b0);
        step("s15", 4'd15, e15, 1'b0);
        step("s0",  4'd0,  e0,  1'b1);
        step("s1",  4'd1,  e1,  1'b0);
        chk("no_ovr", 32'(overrun), 32'd0);

        // Overrun: 2 held while 3 is accepted with consumer stalled
        rd_ready = 1'b0;
        reset    = 1'b0;
        q_in     = 4'd2;
        tick();
        reset = 1'b1;
        got   = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (rd_valid) got = 1'b1;
        end
        chk("ovr_first_seen", 32'(got),   32'd1);
        chk("ovr_first_cnt",  32'(count), 32'd2);
        q_in = 4'd3;
        repeat (6) tick();
        chk("ovr_flag", 32'(overrun),  32'd1);
        chk("ovr_cnt",  32'(count),    32'd2);
        chk("ovr_vld",  32'(rd_valid), 32'd1);

        // One reset edge clears everything
        reset = 1'b0;
        tick();
        chk("rst2_ovr",  32'(overrun),    32'd0);
        chk("rst2_vld",  32'(rd_valid),   32'd0);
        chk("rst2_cnt",  32'(count),      32'd0);
        chk("rst2_wrap", 32'(wrap_pulse), 32'd0);
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ripple_capture.md
# ripple_capture

Synchronous capture stage downstream of the 4-bit mod-16 ripple counter. It samples the asynchronous ripple outputs into the `clk` domain and rejects transient codes while the ripple settles. Each settled new value is extended to a wider count by tracking wrap-arounds. The extended count is presented over a valid/ready handshake to the consuming logic.

## Interface
- `EXT_W`, 12: width of extended count; must be ≥ 5.
- `STABLE_N`, 2: consecutive identical synchronized samples required before a value is accepted; range 1–15.

- `clk` in 1: capture clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `q_in` in 4: raw ripple counter outputs; asynchronous to `clk`.
- `rd_valid` out 1: `count` holds an unconsumed accepted value.
- `rd_ready` in 1: consumer accepts `count` on an edge where `rd_valid && rd_ready`.
- `count` out EXT_W: `{upper[EXT_W-5:0], nibble[3:0]}` of the last loaded value.
- `wrap_pulse` out 1: one-cycle pulse on the edge a wrap is accepted.
- `overrun` out 1: sticky flag; a value was accepted while the output register was full and not being read.

## Operation
- Two-flop synchronizer per bit: `s1 <= q_in`, then `s2 <= s1`.
- Stability filter, with registers `cand[3:0]` and `stab` (4 bits):
  - if `s2 != cand`: `cand <= s2`, `stab <= 1`;
  - else if `stab < STABLE_N`: `stab <= stab + 1`.
- Accept event: on the edge where `stab` becomes `STABLE_N` (for `STABLE_N=1`, the edge where `cand` loads), if `cand != last`.
  - `last <= cand`.
  - If `cand < last`, this is a wrap: `upper <= upper + 1` (modulo 2^(EXT_W-4)), and `wrap_pulse` = 1 for that cycle.
- Any drop in value counts as a wrap. This includes a ripple counter reset to 0 from a nonzero value. Skipped codes (e.g. 3→6) are accepted without error.
- Output register update rule:
  - Load `count`/`rd_valid` on an accept when `!rd_valid || rd_ready`. If the accept and the read occur on the same edge, the new value loads and `rd_valid` stays 1.
  - On an accept while `rd_valid && !rd_ready`: `count` is held unchanged, the new value is dropped from the output (`last`/`upper` still update), and `overrun <= 1`.
  - On a read with no accept: `rd_valid <= 0`.
- Handshake rule: `count` is stable while `rd_valid && !rd_ready`.

## Timing
- On reset: `s1`, `s2`, `cand`, `last`, `upper` = 0; `stab` = `STABLE_N`; `rd_valid` = 0; `count` = 0; `wrap_pulse` = 0; `overrun` = 0.
- Latency: a `q_in` change setting up before rising edge 1 gives `rd_valid`/`count` updated at edge 2+`STABLE_N`. This is edge 4 for the default.
- Throughput: at most one accept per `STABLE_N` cycles.
- Reset mid-operation: all state returns to reset values at that edge, and any pending output is discarded. A `q_in` that is nonzero at reset release is accepted as a new value with no wrap.
- `reset` low overrides all other inputs.

## Configuration
- `RIPPLE_CAPTURE_EXT_EN` defined: the `upper` tracker is present and `count[EXT_W-1:4]` = `upper`.
- Not defined: `upper` is removed and `count[EXT_W-1:4]` = 0. `wrap_pulse` still operates.
- The handshake and `overrun` behave identically in both builds.

## Test plan
- Reset, then `q_in` held at 0 with `rd_ready`=1 → `rd_valid` stays 0 and all outputs stay 0.
- `q_in` 0→5 before edge 1, `rd_ready`=0 → at edge 4 `rd_valid`=1 and `count`=5; `count` holds until `rd_ready`=1, after which `rd_valid`=0 on the next edge.
- One-cycle glitch to 7 inside a stable 5 → no accept and `count` unchanged.
- Steps 14→15→0→1 with `rd_ready`=1 and the macro defined → `count` reads 14, 15, 16, 17; one `wrap_pulse` is seen on the 0 accept.
- Same sequence with the macro undefined → `count` reads 14, 15, 0, 1.
- `rd_ready`=0, values 2 then 3 accepted → `count`=2 is held and `overrun`=1. Asserting `reset`=0 for one edge then clears `overrun`, `rd_valid` and `count`.
